// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared definitions for the stopwatch front-end control:
//               FSM state encoding and a minimum-width helper used to size
//               the prescaler and debounce counters.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchroniser, stable-sample counter and rising-edge
//               pulse for one raw mechanical key. The debounced level only
//               follows the synchronised key after DB consecutive samples that
//               disagree with the current debounced level; a single 1-cycle
//               press pulse accompanies each debounced 0->1 change.
// Ports       : clk     in  system clock
//               rst_n   in  asynchronous active-low reset
//               key_raw in  raw key, active-high, asynchronous to clk
//               press   out 1-cycle pulse per debounced press
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int              c_CW       = clog2_min1(DB);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DB - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_press;
  logic [c_CW-1:0] r_cnt;

  logic w_differ;
  logic w_settle;

  // The counter only runs while the synchronised key disagrees with the
  // debounced level; any agreeing sample restarts the stability window.
  assign w_differ = (r_sync2 != r_level);
  assign w_settle = w_differ && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
      if (!w_differ || w_settle) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_CW'(1);
      end
      if (w_settle) begin
        r_level <= r_sync2;
      end
      // Only the press edge pulses; release settles silently.
      r_press <= w_settle && r_sync2;
    end
  end

  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch front-end control. Debounces START/STOP and RESET
//               keys, runs the IDLE/RUN/PAUSE FSM and drives the count enable
//               (tick_en, one pulse per DIV RUN cycles) and the synchronous
//               clear (clr) of the downstream timing counter chain.
//               Optional lap feature enabled by defining STOPWATCH_LAP_EN.
// Ports       : clk       in  system clock
//               rst_n     in  asynchronous active-low reset
//               key_start in  raw START/STOP key, active-high
//               key_reset in  raw RESET key, active-high
//               key_lap   in  raw LAP key (STOPWATCH_LAP_EN only)
//               lap_hold  out display freeze request (STOPWATCH_LAP_EN only)
//               tick_en   out 1-cycle count enable to the timing chain
//               clr       out 1-cycle synchronous clear to the timing chain
//               running   out high while the FSM is in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_start,
  input  logic key_reset,
`ifdef STOPWATCH_LAP_EN
  input  logic key_lap,
  output logic lap_hold,
`endif
  output logic tick_en,
  output logic clr,
  output logic running
);

  localparam int              c_DIV        = CLK_FREQ / TICK_HZ;
  localparam int              c_DB         = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int              c_PW         = clog2_min1(c_DIV);
  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(c_DIV - 1);

  // --------------------------------------------------------------------------
  // Key front ends
  // --------------------------------------------------------------------------
  logic w_start_press;
  logic w_reset_press;

  key_debounce #(.DB(c_DB)) u_db_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_start),
    .press   (w_start_press)
  );

  key_debounce #(.DB(c_DB)) u_db_reset (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_reset),
    .press   (w_reset_press)
  );

`ifdef STOPWATCH_LAP_EN
  logic w_lap_press;
  logic r_lap_hold;
  logic w_lap_hold_nxt;

  key_debounce #(.DB(c_DB)) u_db_lap (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_lap),
    .press   (w_lap_press)
  );
`endif

  // --------------------------------------------------------------------------
  // FSM, prescaler and output registers
  // --------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_PW-1:0] r_presc;
  logic [c_PW-1:0] w_presc_nxt;
  logic            r_tick;
  logic            w_tick_nxt;
  logic            r_clr;
  logic            w_clr_nxt;
  logic            r_running;
  logic            w_running_nxt;
  logic            w_presc_wrap;

  assign w_presc_wrap = (r_presc == c_PRESC_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    w_clr_nxt   = 1'b0;

    // The prescaler advances on every RUN cycle, including the cycle the FSM
    // leaves RUN, so a wrap in that cycle still yields its tick.
    if (r_state == ST_RUN) begin
      w_presc_nxt = w_presc_wrap ? '0 : (r_presc + c_PW'(1));
      w_tick_nxt  = w_presc_wrap;
    end

    if (w_reset_press) begin
      // Reset outranks start and any pending tick, so tick_en and clr are
      // never asserted together.
      w_state_nxt = ST_IDLE;
      w_presc_nxt = '0;
      w_tick_nxt  = 1'b0;
      w_clr_nxt   = 1'b1;
    end else if (w_start_press) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end

    w_running_nxt = (w_state_nxt == ST_RUN);

`ifdef STOPWATCH_LAP_EN
    w_lap_hold_nxt = r_lap_hold;
    if (w_reset_press) begin
      w_lap_hold_nxt = 1'b0;
    end else if (w_lap_press && (r_state != ST_IDLE)) begin
      w_lap_hold_nxt = ~r_lap_hold;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_clr     <= 1'b1;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_tick    <= w_tick_nxt;
      r_clr     <= w_clr_nxt;
      r_running <= w_running_nxt;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_hold <= 1'b0;
    end else begin
      r_lap_hold <= w_lap_hold_nxt;
    end
  end

  assign lap_hold = r_lap_hold;
`endif

  assign tick_en = r_tick;
  assign clr     = r_clr;
  assign running = r_running;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed self-checking bench for stopwatch_ctrl with
//               CLK_FREQ=1000, TICK_HZ=100 (DIV=10), DEBOUNCE_MS=20 (DB=20).
//               Lap checks are compiled when STOPWATCH_LAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  logic clk;
  logic rst_n;
  logic key_start;
  logic key_reset;
  logic key_lap;
  logic tick_en;
  logic clr;
  logic running;
`ifdef STOPWATCH_LAP_EN
  logic lap_hold;
`endif

  int n_checks;
  int n_fail;

  // Activity monitor, sampled 1 time unit after each rising edge.
  int   tick_cnt;
  int   clr_cnt;
  int   rise_cnt;
  int   gap_bad;
  int   last_gap;
  int   run_since;
  int   overlap_cnt;
  logic prev_running;

  stopwatch_ctrl #(
    .CLK_FREQ    (1000),
    .TICK_HZ     (100),
    .DEBOUNCE_MS (20)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_start (key_start),
    .key_reset (key_reset),
`ifdef STOPWATCH_LAP_EN
    .key_lap   (key_lap),
    .lap_hold  (lap_hold),
`endif
    .tick_en   (tick_en),
    .clr       (clr),
    .running   (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick_cnt     = 0;
    clr_cnt      = 0;
    rise_cnt     = 0;
    gap_bad      = 0;
    last_gap     = 0;
    run_since    = 0;
    overlap_cnt  = 0;
    prev_running = 1'b0;
  end

  // run_since counts RUN cycles since the last tick (tick cycle included);
  // each tick must arrive after exactly 10 such cycles.
  always @(posedge clk) begin
    #1;
    if (tick_en === 1'b1) begin
      tick_cnt = tick_cnt + 1;
      last_gap = run_since;
      if (run_since != 10) gap_bad = gap_bad + 1;
      run_since = (running === 1'b1) ? 1 : 0;
    end else if (running === 1'b1) begin
      run_since = run_since + 1;
    end
    if (tick_en === 1'b1 && clr === 1'b1) overlap_cnt = overlap_cnt + 1;
    if (clr === 1'b1) begin
      clr_cnt   = clr_cnt + 1;
      run_since = 0;
    end
    if (running === 1'b1 && prev_running !== 1'b1) rise_cnt = rise_cnt + 1;
    prev_running = running;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus only: hold one key for 30 cycles, then release and let it settle.
  task automatic press_key(input int which);
    case (which)
      0:       key_start = 1'b1;
      1:       key_reset = 1'b1;
      default: key_lap   = 1'b1;
    endcase
    repeat (30) @(negedge clk);
    key_start = 1'b0;
    key_reset = 1'b0;
    key_lap   = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    key_start = 1'b0;
    key_reset = 1'b0;
    key_lap   = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (clr !== 1'b1) begin n_fail++; $display("FAIL reset_clr: got %b expected 1", clr); end
    n_checks++;
    if (tick_en !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick_en); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (clr !== 1'b1) begin n_fail++; $display("FAIL release_clr_held: got %b expected 1", clr); end
    @(negedge clk);
    n_checks++;
    if (clr !== 1'b0) begin n_fail++; $display("FAIL release_clr_drop: got %b expected 0", clr); end
    n_checks++;
    if (u_dut.r_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", u_dut.r_state); end
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 12; i++) begin
      key_start = ~key_start;
      repeat (5) @(negedge clk);
    end
    n_checks++;
    if (rise_cnt !== 0) begin n_fail++; $display("FAIL bounce_no_pulse: got %0d run entries expected 0", rise_cnt); end
    key_start = 1'b1;
    repeat (100) @(negedge clk);
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL hold_running: got %b expected 1", running); end
    n_checks++;
    if (rise_cnt !== 1) begin n_fail++; $display("FAIL hold_one_pulse: got %0d run entries expected 1", rise_cnt); end
    key_start = 1'b0;
    repeat (60) @(negedge clk);
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL release_no_pulse: got running %b expected 1", running); end
  endtask

  task automatic test_run_rate();
    int t0;
    int b0;
    t0 = tick_cnt;
    b0 = gap_bad;
    repeat (1000) @(negedge clk);
    n_checks++;
    if (tick_cnt - t0 !== 100) begin n_fail++; $display("FAIL run_rate_count: got %0d expected 100", tick_cnt - t0); end
    n_checks++;
    if (gap_bad - b0 !== 0) begin n_fail++; $display("FAIL run_rate_spacing: got %0d bad gaps expected 0", gap_bad - b0); end
    n_checks++;
    if (last_gap !== 10) begin n_fail++; $display("FAIL run_rate_gap: got %0d expected 10", last_gap); end
  endtask

  task automatic test_pause_phase();
    int n;
    int t0;
    int pause_runs;
    n = 0;
    while (tick_en !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    // Key rises 11 cycles after this tick; the 2-flop sync plus 20 samples
    // plus the FSM register place the pause 3 RUN cycles after the next tick.
    repeat (10) @(negedge clk);
    key_start = 1'b1;
    n = 0;
    while (running !== 1'b0 && n < 80) begin @(negedge clk); n++; end
    key_start  = 1'b0;
    pause_runs = run_since;
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL pause_entry: got running %b expected 0", running); end
    n_checks++;
    if (pause_runs !== 3) begin n_fail++; $display("FAIL pause_phase: got %0d run cycles expected 3", pause_runs); end
    t0 = tick_cnt;
    repeat (500) @(negedge clk);
    n_checks++;
    if (tick_cnt - t0 !== 0) begin n_fail++; $display("FAIL pause_no_tick: got %0d expected 0", tick_cnt - t0); end
    key_start = 1'b1;
    n = 0;
    while (running !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    key_start = 1'b0;
    n = 0;
    while (tick_en !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_checks++;
    if (n !== 7) begin n_fail++; $display("FAIL resume_phase: got %0d run cycles expected 7", n); end
    n_checks++;
    if (last_gap !== 10) begin n_fail++; $display("FAIL resume_gap: got %0d expected 10", last_gap); end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset_priority();
    int n;
    int c0;
    c0 = clr_cnt;
    key_start = 1'b1;
    key_reset = 1'b1;
    n = 0;
    while (running !== 1'b0 && n < 80) begin @(negedge clk); n++; end
    n_checks++;
    if (clr !== 1'b1) begin n_fail++; $display("FAIL prio_clr_pulse: got %b expected 1", clr); end
    key_start = 1'b0;
    key_reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (clr !== 1'b0) begin n_fail++; $display("FAIL prio_clr_width: got %b expected 0", clr); end
    n_checks++;
    if (u_dut.r_state !== 2'd0) begin n_fail++; $display("FAIL prio_state: got %0d expected 0", u_dut.r_state); end
    n_checks++;
    if (u_dut.r_presc !== 0) begin n_fail++; $display("FAIL prio_presc: got %0d expected 0", u_dut.r_presc); end
    repeat (40) @(negedge clk);
    n_checks++;
    if (clr_cnt - c0 !== 1) begin n_fail++; $display("FAIL prio_clr_count: got %0d expected 1", clr_cnt - c0); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL prio_running: got %b expected 0", running); end
    n_checks++;
    if (overlap_cnt !== 0) begin n_fail++; $display("FAIL tick_clr_overlap: got %0d expected 0", overlap_cnt); end
  endtask

  task automatic test_idle_reset();
    int c0;
    c0 = clr_cnt;
    press_key(1);
    n_checks++;
    if (clr_cnt - c0 !== 1) begin n_fail++; $display("FAIL idle_reset_clr: got %0d expected 1", clr_cnt - c0); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL idle_reset_running: got %b expected 0", running); end
  endtask

  task automatic test_async_reset();
    int t0;
    press_key(0);
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL async_pre_run: got %b expected 1", running); end
    repeat (37) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL async_running: got %b expected 0", running); end
    n_checks++;
    if (clr !== 1'b1) begin n_fail++; $display("FAIL async_clr: got %b expected 1", clr); end
    n_checks++;
    if (tick_en !== 1'b0) begin n_fail++; $display("FAIL async_tick: got %b expected 0", tick_en); end
    t0 = tick_cnt;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    n_checks++;
    if (tick_cnt - t0 !== 0) begin n_fail++; $display("FAIL async_no_tick: got %0d expected 0", tick_cnt - t0); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL async_idle: got %b expected 0", running); end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    int t0;
    press_key(2);
    n_checks++;
    if (lap_hold !== 1'b0) begin n_fail++; $display("FAIL lap_idle_ignored: got %b expected 0", lap_hold); end
    press_key(0);
    press_key(2);
    n_checks++;
    if (lap_hold !== 1'b1) begin n_fail++; $display("FAIL lap_set: got %b expected 1", lap_hold); end
    t0 = tick_cnt;
    repeat (100) @(negedge clk);
    n_checks++;
    if (tick_cnt - t0 !== 10) begin n_fail++; $display("FAIL lap_ticks: got %0d expected 10", tick_cnt - t0); end
    press_key(2);
    n_checks++;
    if (lap_hold !== 1'b0) begin n_fail++; $display("FAIL lap_clear: got %b expected 0", lap_hold); end
    press_key(2);
    press_key(1);
    n_checks++;
    if (lap_hold !== 1'b0) begin n_fail++; $display("FAIL lap_reset: got %b expected 0", lap_hold); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL lap_reset_idle: got %b expected 0", running); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_debounce();
    test_run_rate();
    test_pause_phase();
    test_reset_priority();
    test_idle_reset();
    test_async_reset();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
